// File: rtl/obi_ram_data_bridge.sv
// OBI data port to single-cycle RAM bridge with in-order response FIFO.
// Optional LFSR stall injection when RAM_STALL_RANDOM_EN is defined.
module obi_ram_data_bridge #(
  parameter int              ADDR_WIDTH = 22,
  parameter int              RSP_DEPTH  = 4,
  parameter logic [15:0]     LFSR_SEED  = 16'hACE1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  data_req_i,
  output logic                  data_gnt_o,
  input  logic [31:0]           data_addr_i,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [31:0]           data_wdata_i,
  output logic                  data_rvalid_o,
  output logic [31:0]           data_rdata_o,
  output logic                  ram_en_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_we_o,
  output logic [3:0]            ram_be_o,
  output logic [31:0]           ram_wdata_o,
  input  logic [31:0]           ram_rdata_i,
  output logic [15:0]           oor_cnt_o
);

  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(RSP_DEPTH);

  logic gnt_stall;
  logic rsp_stall;

`ifdef RAM_STALL_RANDOM_EN
  logic [15:0] lfsr;
  logic        lfsr_fb;

  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  always_ff @(posedge clk_i) begin
    if (rst_i) lfsr <= LFSR_SEED;
    else       lfsr <= {lfsr[14:0], lfsr_fb};
  end

  assign gnt_stall = (lfsr[1:0] == 2'b00);
  assign rsp_stall = (lfsr[3:2] == 2'b00);
`else
  logic unused_seed;
  assign unused_seed = ^LFSR_SEED;
  assign gnt_stall   = 1'b0;
  assign rsp_stall   = 1'b0;
`endif

  logic          pend_valid;
  logic          pend_read;
  logic          pend_inr;
  logic [31:0]   fifo_mem [RSP_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW:0]   occ;
  logic          in_range;
  logic          xfer;
  logic          fifo_empty;
  logic          pop;
  logic          bypass;
  logic          push;
  logic [31:0]   rsp_word;

  assign occ      = {1'b0, count} + {{CW{1'b0}}, pend_valid};
  assign in_range = (data_addr_i[31:ADDR_WIDTH] == '0);

  assign data_gnt_o = !rst_i && data_req_i
                    && (occ < DEPTH_L) && !gnt_stall;
  assign xfer       = data_req_i && data_gnt_o;

  // Out-of-range transfers never touch the RAM
  assign ram_en_o    = xfer && in_range;
  assign ram_addr_o  = ram_en_o ? data_addr_i[ADDR_WIDTH-1:0] : '0;
  assign ram_we_o    = ram_en_o && data_we_i;
  assign ram_be_o    = ram_en_o ? data_be_i : 4'h0;
  assign ram_wdata_o = ram_en_o ? data_wdata_i : 32'h0;

  assign rsp_word   = (pend_read && pend_inr) ? ram_rdata_i : 32'h0;
  assign fifo_empty = (count == '0);
  assign pop        = !fifo_empty && !rsp_stall;
  assign bypass     = pend_valid && fifo_empty && !rsp_stall;
  assign push       = pend_valid && !bypass;

  always_comb begin
    data_rvalid_o = 1'b0;
    data_rdata_o  = 32'h0;
    if (!rst_i) begin
      if (pop) begin
        data_rvalid_o = 1'b1;
        data_rdata_o  = fifo_mem[rd_ptr];
      end else if (bypass) begin
        data_rvalid_o = 1'b1;
        data_rdata_o  = rsp_word;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_valid <= 1'b0;
      pend_read  <= 1'b0;
      pend_inr   <= 1'b0;
    end else begin
      pend_valid <= xfer;
      pend_read  <= xfer && !data_we_i;
      pend_inr   <= xfer && in_range;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr] <= rsp_word;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      oor_cnt_o <= 16'h0;
    end else if (xfer && !in_range
                 && oor_cnt_o != 16'hFFFF) begin
      oor_cnt_o <= oor_cnt_o + 16'h1;
    end
  end

endmodule
